// File: rtl/i2si_pkg.sv
// Shared parameters and state encoding for the I2S input deserialiser.
package i2si_pkg;

   localparam int unsigned WORD_W_DEF   = 12;
   localparam int unsigned BIST_DIV_DEF = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ALIGN = 2'd1,
      ST_RUN   = 2'd2,
      ST_BIST  = 2'd3
   } state_e;

endpackage

// File: rtl/i2si_sync.sv
// Two-flop synchronisers for the external I2S pins plus a registered SCK rising-edge pulse.
// ws/sd leave with the same delay as sck_rise so they are sampled in step with it.
module i2si_sync (
   input  logic clk,
   input  logic rst,
   input  logic i2s_sck,
   input  logic i2s_ws,
   input  logic i2s_sd,
   output logic sck_rise,
   output logic ws,
   output logic sd
);

   logic sck_m, sck_s, sck_d;
   logic ws_m, ws_s;
   logic sd_m, sd_s;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sck_m    <= 1'b0;
         sck_s    <= 1'b0;
         sck_d    <= 1'b0;
         ws_m     <= 1'b0;
         ws_s     <= 1'b0;
         sd_m     <= 1'b0;
         sd_s     <= 1'b0;
         sck_rise <= 1'b0;
         ws       <= 1'b0;
         sd       <= 1'b0;
      end else begin
         sck_m    <= i2s_sck;
         sck_s    <= sck_m;
         sck_d    <= sck_s;
         ws_m     <= i2s_ws;
         ws_s     <= ws_m;
         sd_m     <= i2s_sd;
         sd_s     <= sd_m;
         sck_rise <= sck_s & ~sck_d;
         ws       <= ws_s;
         sd       <= sd_s;
      end
   end

endmodule

// File: rtl/i2si_deser.sv
// I2S / BIST front end: deserialises MSB-first left/right words and emits a
// per-frame strobe; in BIST mode frames are built from the generator word.
module i2si_deser
   import i2si_pkg::*;
#(
   parameter int unsigned WORD_W   = WORD_W_DEF,
   parameter int unsigned BIST_DIV = BIST_DIV_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i2s_sck,
   input  logic              i2s_ws,
   input  logic              i2s_sd,
   input  logic              rf_i2si_en,
   input  logic              rf_bist_en,
   input  logic [WORD_W-1:0] i2si_bist_out_data,
   output logic [WORD_W-1:0] i2si_left_data,
   output logic [WORD_W-1:0] i2si_right_data,
   output logic              i2si_frame_vld,
   output logic              i2si_short_err
);

   localparam int unsigned CNT_W = $clog2(WORD_W + 1);
   localparam int unsigned DIV_W = (BIST_DIV > 2) ? $clog2(BIST_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WORD_W);
   localparam logic [DIV_W-1:0] DIV_TC  = DIV_W'(BIST_DIV - 1);

   logic sck_rise, ws_s, sd_s;

   state_e            state_q, state_d;
   logic [WORD_W-1:0] shift_q, shift_d, sh_tmp, word_tmp;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_tmp;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              left_ok_q, left_ok_d;
   logic              ws_prev_q, ws_prev_d;
   logic [WORD_W-1:0] left_d, right_d;
   logic              frame_vld_d, short_err_d;

   i2si_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .i2s_sck  (i2s_sck),
      .i2s_ws   (i2s_ws),
      .i2s_sd   (i2s_sd),
      .sck_rise (sck_rise),
      .ws       (ws_s),
      .sd       (sd_s)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= ST_IDLE;
         shift_q         <= '0;
         cnt_q           <= '0;
         div_q           <= '0;
         left_ok_q       <= 1'b0;
         ws_prev_q       <= 1'b0;
         i2si_left_data  <= '0;
         i2si_right_data <= '0;
         i2si_frame_vld  <= 1'b0;
         i2si_short_err  <= 1'b0;
      end else begin
         state_q         <= state_d;
         shift_q         <= shift_d;
         cnt_q           <= cnt_d;
         div_q           <= div_d;
         left_ok_q       <= left_ok_d;
         ws_prev_q       <= ws_prev_d;
         i2si_left_data  <= left_d;
         i2si_right_data <= right_d;
         i2si_frame_vld  <= frame_vld_d;
         i2si_short_err  <= short_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      div_d       = div_q;
      left_ok_d   = left_ok_q;
      ws_prev_d   = sck_rise ? ws_s : ws_prev_q;
      left_d      = i2si_left_data;
      right_d     = i2si_right_data;
      frame_vld_d = 1'b0;
      short_err_d = 1'b0;

      // Shift-in candidate; bits past a full word are dropped and cnt saturates.
      sh_tmp  = shift_q;
      cnt_tmp = cnt_q;
      if (cnt_q < CNT_MAX) begin
         sh_tmp  = {shift_q[WORD_W-2:0], sd_s};
         cnt_tmp = cnt_q + CNT_W'(1);
      end
      word_tmp = sh_tmp << (CNT_MAX - cnt_tmp);

      unique case (state_q)
         ST_IDLE: begin
            shift_d   = '0;
            cnt_d     = '0;
            div_d     = '0;
            left_ok_d = 1'b0;
            if (rf_i2si_en) state_d = rf_bist_en ? ST_BIST : ST_ALIGN;
         end
         ST_ALIGN: begin
            if (sck_rise && (ws_s != ws_prev_q)) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (sck_rise) begin
               shift_d = sh_tmp;
               cnt_d   = cnt_tmp;
               // A WS change marks this bit as the previous channel's LSB.
               if (ws_s != ws_prev_q) begin
                  if (!ws_prev_q) begin
                     left_d    = word_tmp;
                     left_ok_d = 1'b1;
                  end else begin
                     right_d     = word_tmp;
                     frame_vld_d = left_ok_q;
                     left_ok_d   = 1'b0;
                  end
                  short_err_d = (cnt_tmp < CNT_MAX);
                  shift_d     = '0;
                  cnt_d       = '0;
               end
            end
         end
         ST_BIST: begin
            if (div_q == DIV_TC) begin
               div_d       = '0;
               left_d      = i2si_bist_out_data;
               right_d     = i2si_bist_out_data;
               frame_vld_d = 1'b1;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Disable or a mode change drops back to IDLE; data outputs hold.
      if (!rf_i2si_en ||
          (rf_bist_en && ((state_q == ST_ALIGN) || (state_q == ST_RUN))) ||
          (!rf_bist_en && (state_q == ST_BIST))) begin
         state_d     = ST_IDLE;
         shift_d     = '0;
         cnt_d       = '0;
         div_d       = '0;
         left_ok_d   = 1'b0;
         left_d      = i2si_left_data;
         right_d     = i2si_right_data;
         frame_vld_d = 1'b0;
         short_err_d = 1'b0;
      end
   end

endmodule

// File: tb/tb_i2si_deser.sv
// Directed bench for i2si_deser: I2S framing, short words, alignment, BIST, mode switch, reset.
module tb_i2si_deser;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i2s_sck = 1'b0;
   logic        i2s_ws = 1'b0;
   logic        i2s_sd = 1'b0;
   logic        rf_i2si_en = 1'b0;
   logic        rf_bist_en = 1'b0;
   logic [11:0] i2si_bist_out_data = '0;
   logic [11:0] i2si_left_data;
   logic [11:0] i2si_right_data;
   logic        i2si_frame_vld;
   logic        i2si_short_err;

   int checks = 0;
   int errors = 0;
   int fv_cnt = 0;
   int se_cnt = 0;

   i2si_deser #(.WORD_W(12), .BIST_DIV(4)) dut (
      .clk                (clk),
      .rst                (rst),
      .i2s_sck            (i2s_sck),
      .i2s_ws             (i2s_ws),
      .i2s_sd             (i2s_sd),
      .rf_i2si_en         (rf_i2si_en),
      .rf_bist_en         (rf_bist_en),
      .i2si_bist_out_data (i2si_bist_out_data),
      .i2si_left_data     (i2si_left_data),
      .i2si_right_data    (i2si_right_data),
      .i2si_frame_vld     (i2si_frame_vld),
      .i2si_short_err     (i2si_short_err)
   );

   always #5 clk = ~clk;

   // Strobe tally sampled mid-cycle.
   always @(negedge clk) begin
      if (i2si_frame_vld) fv_cnt++;
      if (i2si_short_err) se_cnt++;
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   // One SCK period (6 clks), data and WS change while SCK is low.
   task automatic send_bit(input logic w, input logic b);
      i2s_sck = 1'b0;
      i2s_ws  = w;
      i2s_sd  = b;
      #30;
      i2s_sck = 1'b1;
      #30;
   endtask

   // WS leads data by one bit: the slot's last bit already carries the next channel's WS.
   task automatic send_slot(input logic ch, input logic [11:0] data, input int wbits,
                            input int slot, input logic next_ch);
      logic b;
      for (int i = 0; i < slot; i++) begin
         b = (i < wbits) ? data[wbits-1-i] : 1'b0;
         send_bit((i == slot - 1) ? next_ch : ch, b);
      end
   endtask

   task automatic send_frame(input logic [11:0] l, input logic [11:0] r,
                             input int wbits, input int slot);
      send_slot(1'b0, l, wbits, slot, 1'b1);
      send_slot(1'b1, r, wbits, slot, 1'b0);
   endtask

   task automatic test_reset;
      rst = 1'b0;
      wait_clks(3);
      checks++; if (i2si_left_data !== 12'h000) begin errors++; $display("FAIL reset_left: got %h exp 000", i2si_left_data); end
      checks++; if (i2si_right_data !== 12'h000) begin errors++; $display("FAIL reset_right: got %h exp 000", i2si_right_data); end
      checks++; if (i2si_frame_vld !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b exp 0", i2si_frame_vld); end
      checks++; if (i2si_short_err !== 1'b0) begin errors++; $display("FAIL reset_se: got %b exp 0", i2si_short_err); end
      @(negedge clk);
      rst = 1'b1;
      wait_clks(2);
   endtask

   task automatic test_i2s_normal;
      int fv0, se0;
      rf_bist_en = 1'b0;
      rf_i2si_en = 1'b1;
      wait_clks(4);
      fv0 = fv_cnt;
      se0 = se_cnt;
      send_slot(1'b1, 12'h000, 12, 16, 1'b0);
      send_frame(12'hA5C, 12'h3F1, 12, 16);
      send_frame(12'hA5C, 12'h3F1, 12, 16);
      wait_clks(8);
      checks++; if (i2si_left_data !== 12'hA5C) begin errors++; $display("FAIL norm_left2: got %h exp a5c", i2si_left_data); end
      checks++; if (i2si_right_data !== 12'h3F1) begin errors++; $display("FAIL norm_right2: got %h exp 3f1", i2si_right_data); end
      checks++; if (fv_cnt - fv0 !== 2) begin errors++; $display("FAIL norm_fv2: got %0d exp 2", fv_cnt - fv0); end
      send_frame(12'hA5C, 12'h3F1, 12, 16);
      wait_clks(8);
      checks++; if (fv_cnt - fv0 !== 3) begin errors++; $display("FAIL norm_fv3: got %0d exp 3", fv_cnt - fv0); end
      checks++; if (se_cnt - se0 !== 0) begin errors++; $display("FAIL norm_se: got %0d exp 0", se_cnt - se0); end
      checks++; if (i2si_left_data !== 12'hA5C) begin errors++; $display("FAIL norm_left3: got %h exp a5c", i2si_left_data); end
   endtask

   task automatic test_short_word;
      int fv0, se0;
      rf_i2si_en = 1'b0;
      wait_clks(3);
      checks++; if (i2si_left_data !== 12'hA5C) begin errors++; $display("FAIL dis_hold: got %h exp a5c", i2si_left_data); end
      rf_i2si_en = 1'b1;
      wait_clks(4);
      send_slot(1'b1, 12'h000, 8, 8, 1'b0);
      wait_clks(8);
      fv0 = fv_cnt;
      se0 = se_cnt;
      send_frame(12'h0B7, 12'h05A, 8, 8);
      send_frame(12'h0B7, 12'h05A, 8, 8);
      wait_clks(8);
      checks++; if (i2si_left_data !== 12'hB70) begin errors++; $display("FAIL short_left: got %h exp b70", i2si_left_data); end
      checks++; if (i2si_right_data !== 12'h5A0) begin errors++; $display("FAIL short_right: got %h exp 5a0", i2si_right_data); end
      checks++; if (se_cnt - se0 !== 4) begin errors++; $display("FAIL short_se: got %0d exp 4", se_cnt - se0); end
      checks++; if (fv_cnt - fv0 !== 2) begin errors++; $display("FAIL short_fv: got %0d exp 2", fv_cnt - fv0); end
   endtask

   task automatic test_alignment;
      int fv0;
      rf_i2si_en = 1'b0;
      wait_clks(3);
      rf_i2si_en = 1'b1;
      wait_clks(4);
      fv0 = fv_cnt;
      for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1);
      send_bit(1'b1, 1'b1);
      send_slot(1'b1, 12'h789, 12, 16, 1'b0);
      wait_clks(8);
      checks++; if (i2si_right_data !== 12'h789) begin errors++; $display("FAIL align_right0: got %h exp 789", i2si_right_data); end
      checks++; if (fv_cnt - fv0 !== 0) begin errors++; $display("FAIL align_fv0: got %0d exp 0", fv_cnt - fv0); end
      send_slot(1'b0, 12'h123, 12, 16, 1'b1);
      wait_clks(8);
      checks++; if (i2si_left_data !== 12'h123) begin errors++; $display("FAIL align_left: got %h exp 123", i2si_left_data); end
      checks++; if (fv_cnt - fv0 !== 0) begin errors++; $display("FAIL align_fv1: got %0d exp 0", fv_cnt - fv0); end
      send_slot(1'b1, 12'h456, 12, 16, 1'b0);
      wait_clks(8);
      checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL align_fv2: got %0d exp 1", fv_cnt - fv0); end
      checks++; if (i2si_right_data !== 12'h456) begin errors++; $display("FAIL align_right: got %h exp 456", i2si_right_data); end
   endtask

   task automatic test_bist;
      logic [11:0] exp_w;
      int n;
      bit ok;
      exp_w = 12'h001;
      @(negedge clk);
      i2si_bist_out_data = exp_w;
      rf_bist_en = 1'b1;
      for (int k = 0; k < 6; k++) begin
         n = 0;
         ok = 1'b0;
         for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            n++;
            if (i2si_frame_vld) ok = 1'b1;
         end
         checks++; if (!ok) begin errors++; $display("FAIL bist_timeout: got none exp strobe %0d", k); end
         checks++; if (i2si_left_data !== exp_w) begin errors++; $display("FAIL bist_left: got %h exp %h", i2si_left_data, exp_w); end
         checks++; if (i2si_right_data !== exp_w) begin errors++; $display("FAIL bist_right: got %h exp %h", i2si_right_data, exp_w); end
         checks++; if (i2si_short_err !== 1'b0) begin errors++; $display("FAIL bist_se: got %b exp 0", i2si_short_err); end
         if (k > 0) begin
            checks++; if (n !== 4) begin errors++; $display("FAIL bist_period: got %0d exp 4", n); end
         end
         exp_w = (exp_w == 12'h019) ? 12'h001 : exp_w + 12'h001;
         i2si_bist_out_data = exp_w;
      end
   endtask

   task automatic test_mode_switch;
      int n;
      bit ok, hold_ok;
      rf_bist_en = 1'b0;
      wait_clks(4);
      send_slot(1'b1, 12'h000, 12, 16, 1'b0);
      send_frame(12'h2AA, 12'h155, 12, 16);
      wait_clks(8);
      checks++; if (i2si_left_data !== 12'h2AA) begin errors++; $display("FAIL sw_left: got %h exp 2aa", i2si_left_data); end
      checks++; if (i2si_right_data !== 12'h155) begin errors++; $display("FAIL sw_right: got %h exp 155", i2si_right_data); end
      @(negedge clk);
      i2si_bist_out_data = 12'h0AB;
      rf_bist_en = 1'b1;
      n = 0;
      ok = 1'b0;
      hold_ok = 1'b1;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge clk);
         n++;
         if (i2si_frame_vld) ok = 1'b1;
         else if (i2si_left_data !== 12'h2AA || i2si_right_data !== 12'h155) hold_ok = 1'b0;
      end
      checks++; if (!ok) begin errors++; $display("FAIL sw_timeout: got none exp strobe"); end
      checks++; if (n !== 6) begin errors++; $display("FAIL sw_latency: got %0d exp 6", n); end
      checks++; if (!hold_ok) begin errors++; $display("FAIL sw_hold: got changed exp held"); end
      checks++; if (i2si_left_data !== 12'h0AB) begin errors++; $display("FAIL sw_bist_left: got %h exp 0ab", i2si_left_data); end
   endtask

   task automatic test_reset_mid_frame;
      int fv0;
      rf_bist_en = 1'b0;
      wait_clks(4);
      send_slot(1'b1, 12'h000, 12, 16, 1'b0);
      for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b1);
      @(negedge clk);
      #3 rst = 1'b0;
      #1;
      checks++; if (i2si_left_data !== 12'h000) begin errors++; $display("FAIL rst_mid_left: got %h exp 000", i2si_left_data); end
      checks++; if (i2si_right_data !== 12'h000) begin errors++; $display("FAIL rst_mid_right: got %h exp 000", i2si_right_data); end
      checks++; if (i2si_frame_vld !== 1'b0) begin errors++; $display("FAIL rst_mid_fv: got %b exp 0", i2si_frame_vld); end
      checks++; if (i2si_short_err !== 1'b0) begin errors++; $display("FAIL rst_mid_se: got %b exp 0", i2si_short_err); end
      rf_i2si_en = 1'b0;
      wait_clks(2);
      rst = 1'b1;
      wait_clks(2);
      fv0 = fv_cnt;
      send_slot(1'b1, 12'h000, 12, 16, 1'b0);
      send_frame(12'h111, 12'h222, 12, 16);
      wait_clks(8);
      checks++; if (i2si_left_data !== 12'h000) begin errors++; $display("FAIL idle_left: got %h exp 000", i2si_left_data); end
      checks++; if (fv_cnt - fv0 !== 0) begin errors++; $display("FAIL idle_fv: got %0d exp 0", fv_cnt - fv0); end
   endtask

   initial begin
      test_reset;
      test_i2s_normal;
      test_short_word;
      test_alignment;
      test_bist;
      test_mode_switch;
      test_reset_mid_frame;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2si_deser.md
Name: i2si_deser

Overview:
- Front end of the I2S input path; sits alongside and directly downstream of i2si_bist_gen.
- Synchronises the external I2S bus (SCK/WS/SD) into the clk domain and deserialises MSB-first samples into 12-bit left and right words.
- Emits one frame strobe per stereo frame.
- In BIST mode, replaces the live I2S data with i2si_bist_out_data from i2si_bist_gen at a fixed internal frame rate, so later stages see one uniform word stream.

Parameters:
- WORD_W, 12, output word width; must match the BIST generator width.
- BIST_DIV, 64, clk cycles between frame strobes in BIST mode; must be ≥ 2.

Ports:
- clk  in  1  system clock, ≥ 4× I2S SCK.
- rst  in  1  asynchronous, active-low reset.
- i2s_sck  in  1  external bit clock, asynchronous to clk.
- i2s_ws  in  1  external word select: 0 = left, 1 = right.
- i2s_sd  in  1  external serial data.
- rf_i2si_en  in  1  block enable.
- rf_bist_en  in  1  1 = source data from BIST instead of I2S.
- i2si_bist_out_data  in  WORD_W  word from i2si_bist_gen.
- i2si_left_data  out  WORD_W  last complete left word.
- i2si_right_data  out  WORD_W  last complete right word.
- i2si_frame_vld  out  1  one-clk strobe; left and right data are valid for this frame.
- i2si_short_err  out  1  one-clk strobe; the finalised word had fewer than WORD_W bits.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, shift register 0, bit counter 0, left_ok=0, BIST divider 0, state IDLE.
- Synchronisers: i2s_sck, i2s_ws and i2s_sd each pass through 2 flops. SCK rising edge is detected on the synchronised SCK (sck_rise, one clk wide). WS and SD are sampled only on sck_rise. ws_prev holds the WS value from the previous sck_rise.
- State machine:
  - IDLE: leaves when rf_i2si_en=1 and rf_bist_en=0 → ALIGN; when rf_i2si_en=1 and rf_bist_en=1 → BIST.
  - ALIGN: on sck_rise with ws != ws_prev → RUN. Bits received in ALIGN are discarded.
  - RUN: deserialise (rules below).
  - BIST: generate frames from the BIST word (rules below).
  - rf_i2si_en=0 in any state → IDLE next clk; counter, shift register and left_ok are cleared; data outputs hold their values.
  - rf_bist_en changing while enabled → IDLE next clk, then re-enter the other mode.
- RUN, per sck_rise:
  - ws == ws_prev: if cnt < WORD_W, shift SD into the LSB and increment cnt. Bits beyond WORD_W are ignored; cnt saturates at WORD_W.
  - ws != ws_prev (standard I2S: this bit is the LSB of the previous channel): shift it in first, applying the same cnt < WORD_W rule. Then finalise the word: value = shift register << (WORD_W − cnt), zero-padded and left-justified.
    - ws_prev=0: write i2si_left_data and set left_ok.
    - ws_prev=1: write i2si_right_data; if left_ok, pulse i2si_frame_vld; then clear left_ok.
    - Either channel: if cnt < WORD_W after the shift, pulse i2si_short_err.
    - Then clear cnt and the shift register; the next bit is the MSB of channel ws.
  - The finalising update and its strobes are registered: they appear 1 clk after the sck_rise, i.e. 4 clks after the raw SCK edge.
  - A right word with no preceding left word (first frame after ALIGN) updates i2si_right_data but produces no strobe.
- BIST:
  - The divider counts 0..BIST_DIV−1.
  - At terminal count, i2si_left_data and i2si_right_data are both loaded with i2si_bist_out_data, and i2si_frame_vld pulses on the same registered cycle.
  - i2si_short_err is held at 0.
  - I2S pins are ignored.
- Strobes are never asserted for two consecutive clks.

Decomposition:
- Shared package i2si_pkg holds: WORD_W default, BIST_DIV default, and the state encoding (IDLE, ALIGN, RUN, BIST).
- One sub-module, i2si_sync: 2-flop synchroniser for sck/ws/sd, plus the sck_rise edge detector.

Test Plan:
- Reset mid-frame: assert rst during RUN → all outputs 0 immediately, with no clk required; after release, block sits in IDLE.
- I2S normal operation: WORD_W=12, 16 SCK per channel, left 0xA5C, right 0x3F1, 3 frames → after the 2nd frame, left=0xA5C, right=0x3F1, exactly one frame_vld per frame, short_err never asserted.
- Short word: 8-bit slots carrying 0xB7 → left_data=0xB70, short_err pulses per word, frame_vld still pulses.
- Alignment: enable with WS mid-word → no frame_vld until one full left word followed by one full right word has been received after the first WS edge.
- BIST mode: rf_bist_en=1, BIST_DIV=4, generator with start 0x001, inc 0x01, limit 0x019 → frame_vld every 4 clks, left_data==right_data==sampled BIST word, short_err=0.
- Mode switch: toggle rf_bist_en during RUN → IDLE for one clk, enters BIST, first strobe after BIST_DIV clks; data outputs hold in between.
